wm8731_cfg_i2c_master: RTL and testbench
========================================

# wm8731_cfg_i2c_master

Configuration sequencer and I2C write master for the WM8731 codec. After a start request it walks the codec configuration table from index 0 to LUT_SIZE-1, fetching each 16-bit word (7-bit register address, 9-bit value) and sending it to the codec as a three-byte I2C write. It reports completion or NACK failure to the audio top level. It sits between the configuration table and the codec's 2-wire control pins.

## Interface
- CLK_FREQ, 50_000_000: iCLK frequency in Hz.
- I2C_FREQ, 100_000: SCL frequency in Hz.
- DEV_ADDR, 7'h1A: codec 7-bit I2C address.
- LUT_SIZE, 10: number of table words to send.
- iCLK  in  1  system clock. One clock; reset is synchronous and active-high.
- iRST  in  1  synchronous active-high reset.
- iSTART  in  1  one-cycle pulse that starts a configuration pass; ignored while busy.
- LUT_INDEX  out  8  table index.
- LUT_DATA  in  16  table word. The table registers it: valid 1 cycle after LUT_INDEX changes.
- oI2C_SCL  out  1  SCL. Push-pull; the codec never stretches SCL.
- oI2C_SDA_OE  out  1  1 = pull SDA low, 0 = release SDA.
- iI2C_SDA  in  1  sampled SDA line.
- oBUSY  out  1  a pass is in progress.
- oDONE  out  1  level; all words were ACKed. Cleared by iSTART.
- oERR  out  1  level; the pass aborted on a NACK. Cleared by iSTART.

## Operation
- Quarter-bit tick: a counter that wraps at Q = CLK_FREQ/(4*I2C_FREQ) - 1, i.e. 124 by default. It runs only while oBUSY is 1 and is reset to 0 on every state entry.
- FSM states:
  - IDLE: iSTART → FETCH, with index = 0, oDONE = 0, oERR = 0.
  - FETCH: hold for 2 cycles (LUT latency plus margin), latch LUT_DATA into a 16-bit shift source → START.
  - START: SDA falls while SCL is high → BYTE.
  - BYTE: 8 bits, MSB first. Byte 0 = {DEV_ADDR, 1'b0}, byte 1 = word[15:8], byte 2 = word[7:0] → ACK.
  - ACK: release SDA, sample SDA. 0 → next byte, or STOP after byte 2. 1 → NACK handling.
  - STOP: SDA rises while SCL is high → NEXT.
  - NEXT: index == LUT_SIZE-1 → IDLE with oDONE = 1. Otherwise index+1 → FETCH.
  - ERRSTOP: issue STOP → IDLE with oERR = 1.
- Bit phases, 4 ticks per bit:
  - q0: SCL low, SDA updated.
  - q1: SCL low.
  - q2: SCL high; ACK sampled at the end of q2.
  - q3: SCL high.
- START phases: SDA released, SCL high for 2 ticks; then SDA low for 2 ticks.
- STOP phases: SCL low with SDA low for 1 tick; SCL high for 1 tick; SDA released for 2 ticks.
- Index width: 8 bits. LUT_SIZE must lie in 1..256; index 255 never wraps.
- iSTART while oBUSY = 1 is ignored. iSTART in the same cycle as the IDLE return is accepted on the next cycle.
- Reset mid-transfer: all outputs return to reset values in the next cycle. The bus is released (SCL = 1, SDA_OE = 0) without issuing a STOP.

## Timing
- Reset values: LUT_INDEX = 0, oI2C_SCL = 1, oI2C_SDA_OE = 0, oBUSY = 0, oDONE = 0, oERR = 0.
- oBUSY rises in the cycle after iSTART. It falls in the same cycle oDONE or oERR rises.
- Per word (default parameters): 2 + 4·125 (START) + 27·4·125 (3 bytes + 3 ACKs) + 4·125 (STOP) = 14502 cycles.
- Full default pass: 10 × 14502 = 145020 cycles from oBUSY rising to oDONE rising.
- SDA changes only while SCL is low, except at START and STOP.

## Configuration
- WM8731_CFG_RETRY_EN defined:
  - A NACK on any byte issues STOP, then re-fetches and resends the same index.
  - Up to 3 retries per word. The 4th NACK on that word → ERRSTOP.
  - The retry counter clears on every ACKed word.
- WM8731_CFG_RETRY_EN undefined: the first NACK → ERRSTOP.

## Structure
- Package wm8731_cfg_pkg holds:
  - the FSM state enum;
  - DEV_ADDR default (7'h1A);
  - LUT_SIZE default (10);
  - MAX_RETRY (3).
- Sub-module wm8731_i2c_tick: quarter-bit tick generator with an enable and a synchronous clear; outputs a one-cycle tick.

## Test plan
- Reset, then iSTART; the codec model ACKs everything. Required: bytes 0x34, 0x00, 0x17 for word 0; 30 bytes in total ending with 0x12, 0x01; oDONE = 1 exactly 145020 cycles after oBUSY rises.
- Codec model NACKs the address byte of word 4, retry undefined. Required: STOP, oERR = 1, LUT_INDEX = 4, oDONE = 0.
- Same stimulus as the previous scenario, retry defined, with 2 NACKs then ACK on word 4. Required: word 4 sent 3 times, pass completes with oDONE = 1.
- Same stimulus, retry defined, with 4 NACKs on word 4. Required: 4 attempts, then oERR = 1.
- iSTART pulses during word 2. Required: ignored; the byte sequence is unchanged.
- iRST asserted mid-byte of word 6. Required: next cycle SCL = 1, SDA_OE = 0, oBUSY = 0. A subsequent iSTART restarts from index 0.

Source files
------------

// File: rtl/wm8731_cfg_pkg.sv
// Shared types and defaults for the WM8731 configuration I2C master.
package wm8731_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_START   = 3'd2,
        ST_BYTE    = 3'd3,
        ST_ACK     = 3'd4,
        ST_STOP    = 3'd5,
        ST_ERRSTOP = 3'd6
    } state_e;

    localparam logic [6:0]  DEF_DEV_ADDR = 7'h1A;
    localparam int unsigned DEF_LUT_SIZE = 10;
    localparam int unsigned MAX_RETRY    = 3;

    // Byte sel of a three-byte write frame: address+W, register byte, data byte.
    function automatic logic [7:0] frame_byte(input logic [1:0] sel,
                                              input logic [6:0] dev,
                                              input logic [15:0] word);
        case (sel)
            2'd0:    frame_byte = {dev, 1'b0};
            2'd1:    frame_byte = word[15:8];
            default: frame_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/wm8731_i2c_tick.sv
// Quarter-bit tick generator: one-cycle pulse every QMAX+1 enabled cycles.
module wm8731_i2c_tick #(
    parameter int unsigned QMAX = 124
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned W  = (QMAX > 0) ? $clog2(QMAX + 1) : 1;
    localparam logic [W-1:0] QV = W'(QMAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == QV) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && !clr_i && (cnt_q == QV);

endmodule

// File: rtl/wm8731_cfg_i2c_master.sv
// Walks the WM8731 config table and writes each word over I2C.
// Optional NACK retry is enabled by defining WM8731_CFG_RETRY_EN.
module wm8731_cfg_i2c_master
    import wm8731_cfg_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned I2C_FREQ = 100_000,
    parameter logic [6:0]  DEV_ADDR = DEF_DEV_ADDR,
    parameter int unsigned LUT_SIZE = DEF_LUT_SIZE
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    output logic [7:0]  LUT_INDEX,
    input  logic [15:0] LUT_DATA,
    output logic        oI2C_SCL,
    output logic        oI2C_SDA_OE,
    input  logic        iI2C_SDA,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oERR
);
    localparam int unsigned QMAX     = CLK_FREQ / (4 * I2C_FREQ) - 1;
    localparam logic [7:0]  LAST_IDX = 8'(LUT_SIZE - 1);

    state_e      state_q;
    logic [7:0]  idx_q;
    logic [15:0] word_q;
    logic [7:0]  sh_q;
    logic [1:0]  qph_q;
    logic [2:0]  bit_q;
    logic [1:0]  byte_q;
    logic        fetch_q;
    logic        ack_q;
    logic [1:0]  sda_sync_q;
    logic        scl_q, oe_q, busy_q, done_q, err_q;
`ifdef WM8731_CFG_RETRY_EN
    logic [1:0]  retry_cnt_q;
    logic        retry_q;
`endif

    logic       tick_s;
    logic       tick_clr_s;
    logic [1:0] nxt_sel_s;
    logic [7:0] nxt_byte_s;

    // The counter is parked at zero during FETCH so START begins on a full quarter.
    assign tick_clr_s = (state_q == ST_IDLE) || (state_q == ST_FETCH);
    assign nxt_sel_s  = (state_q == ST_ACK) ? byte_q + 2'd1 : 2'd0;
    assign nxt_byte_s = frame_byte(nxt_sel_s, DEV_ADDR, word_q);

    wm8731_i2c_tick #(.QMAX(QMAX)) u_tick (
        .clk_i  (iCLK),
        .rst_i  (iRST),
        .en_i   (busy_q),
        .clr_i  (tick_clr_s),
        .tick_o (tick_s)
    );

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            sda_sync_q <= 2'b11;
        end else begin
            sda_sync_q <= {sda_sync_q[0], iI2C_SDA};
        end
    end

    // Every transition out of a bus state happens on the q3 tick, so qph wraps to 0 on entry.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_IDLE;
            idx_q   <= 8'd0;
            word_q  <= 16'd0;
            sh_q    <= 8'd0;
            qph_q   <= 2'd0;
            bit_q   <= 3'd0;
            byte_q  <= 2'd0;
            fetch_q <= 1'b0;
            ack_q   <= 1'b1;
            scl_q   <= 1'b1;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WM8731_CFG_RETRY_EN
            retry_cnt_q <= 2'd0;
            retry_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (iSTART) begin
                        state_q <= ST_FETCH;
                        idx_q   <= 8'd0;
                        fetch_q <= 1'b0;
                        qph_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
`ifdef WM8731_CFG_RETRY_EN
                        retry_cnt_q <= 2'd0;
                        retry_q     <= 1'b0;
`endif
                    end
                end
                ST_FETCH: begin
                    fetch_q <= 1'b1;
                    if (fetch_q) begin
                        fetch_q <= 1'b0;
                        word_q  <= LUT_DATA;
                        byte_q  <= 2'd0;
                        qph_q   <= 2'd0;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick_s) begin
                        qph_q <= qph_q + 2'd1;
                        if (qph_q == 2'd1) begin
                            oe_q <= 1'b1;
                        end
                        if (qph_q == 2'd3) begin
                            state_q <= ST_BYTE;
                            bit_q   <= 3'd7;
                            sh_q    <= nxt_byte_s;
                            scl_q   <= 1'b0;
                            oe_q    <= ~nxt_byte_s[7];
                        end
                    end
                end
                ST_BYTE: begin
                    if (tick_s) begin
                        qph_q <= qph_q + 2'd1;
                        case (qph_q)
                            2'd1: scl_q <= 1'b1;
                            2'd3: begin
                                scl_q <= 1'b0;
                                if (bit_q == 3'd0) begin
                                    state_q <= ST_ACK;
                                    oe_q    <= 1'b0;
                                end else begin
                                    bit_q <= bit_q - 3'd1;
                                    sh_q  <= {sh_q[6:0], 1'b0};
                                    oe_q  <= ~sh_q[6];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ACK: begin
                    if (tick_s) begin
                        qph_q <= qph_q + 2'd1;
                        case (qph_q)
                            2'd1: scl_q <= 1'b1;
                            2'd2: ack_q <= sda_sync_q[1];
                            2'd3: begin
                                scl_q <= 1'b0;
                                if (!ack_q) begin
                                    if (byte_q == 2'd2) begin
                                        state_q <= ST_STOP;
                                        oe_q    <= 1'b1;
`ifdef WM8731_CFG_RETRY_EN
                                        retry_cnt_q <= 2'd0;
`endif
                                    end else begin
                                        state_q <= ST_BYTE;
                                        byte_q  <= byte_q + 2'd1;
                                        bit_q   <= 3'd7;
                                        sh_q    <= nxt_byte_s;
                                        oe_q    <= ~nxt_byte_s[7];
                                    end
                                end else begin
                                    oe_q <= 1'b1;
`ifdef WM8731_CFG_RETRY_EN
                                    if (retry_cnt_q < 2'(MAX_RETRY)) begin
                                        retry_cnt_q <= retry_cnt_q + 2'd1;
                                        retry_q     <= 1'b1;
                                        state_q     <= ST_STOP;
                                    end else begin
                                        state_q <= ST_ERRSTOP;
                                    end
`else
                                    state_q <= ST_ERRSTOP;
`endif
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STOP, ST_ERRSTOP: begin
                    if (tick_s) begin
                        qph_q <= qph_q + 2'd1;
                        case (qph_q)
                            2'd0: scl_q <= 1'b1;
                            2'd1: oe_q  <= 1'b0;
                            2'd3: begin
                                // Index advance is folded into the STOP's last quarter.
                                if (state_q == ST_ERRSTOP) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    err_q   <= 1'b1;
`ifdef WM8731_CFG_RETRY_EN
                                end else if (retry_q) begin
                                    retry_q <= 1'b0;
                                    state_q <= ST_FETCH;
`endif
                                end else if (idx_q == LAST_IDX) begin
                                    state_q <= ST_IDLE;
                                    busy_q  <= 1'b0;
                                    done_q  <= 1'b1;
                                end else begin
                                    idx_q   <= idx_q + 8'd1;
                                    state_q <= ST_FETCH;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign LUT_INDEX   = idx_q;
    assign oI2C_SCL    = scl_q;
    assign oI2C_SDA_OE = oe_q;
    assign oBUSY       = busy_q;
    assign oDONE       = done_q;
    assign oERR        = err_q;

endmodule

// File: tb/tb_wm8731_cfg_i2c_master.sv
// Self-checking bench: I2C bus decoder, codec ACK/NACK model and a word-level reference model.
module tb_wm8731_cfg_i2c_master;
    localparam int unsigned CLK_F = 1_600_000;
    localparam int unsigned I2C_F = 100_000;
    localparam int          QC    = CLK_F / (4 * I2C_F);
    localparam int          LUT_N = 10;
    localparam logic [6:0]  DEV   = 7'h1A;
    localparam int          LIMIT = 20000;
    localparam int          MAXR  = 3;
`ifdef WM8731_CFG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, scl, oe, busy, done, err;
    logic [7:0]  idx;
    logic [15:0] lut_data;
    logic [15:0] lut [0:15];
    logic        codec_pull = 1'b0;
    logic        sda_line;
    int          total = 0;
    int          bad = 0;

    logic        mon_clr = 1'b1;
    int          nack_idx_cfg = 99;
    int          nack_n_cfg = 0;
    int          nack_left, bitn, byte_no, nstarts, nstops;
    logic [7:0]  shreg;
    logic        prev_scl, prev_sda, sda_now;
    logic [7:0]  got_q [$];
    logic [7:0]  exp_q [$];

    always #5 clk = ~clk;

    assign sda_line = ~(oe | codec_pull);

    always @(posedge clk) lut_data <= (idx < 8'(LUT_N)) ? lut[idx[3:0]] : 16'hDEAD;

    wm8731_cfg_i2c_master #(
        .CLK_FREQ(CLK_F), .I2C_FREQ(I2C_F), .DEV_ADDR(DEV), .LUT_SIZE(LUT_N)
    ) dut (
        .iCLK(clk), .iRST(rst), .iSTART(start), .LUT_INDEX(idx), .LUT_DATA(lut_data),
        .oI2C_SCL(scl), .oI2C_SDA_OE(oe), .iI2C_SDA(sda_line),
        .oBUSY(busy), .oDONE(done), .oERR(err)
    );

    // Bus decoder and codec: logs bytes, counts START/STOP, drives the ACK slot.
    always @(negedge clk) begin
        sda_now = ~(oe | codec_pull);
        if (mon_clr) begin
            codec_pull = 1'b0; bitn = 0; byte_no = 0; nstarts = 0; nstops = 0;
            nack_left = nack_n_cfg; got_q.delete();
        end else if (prev_scl && scl && prev_sda && !sda_now) begin
            nstarts++; bitn = 0; byte_no = 0;
        end else if (prev_scl && scl && !prev_sda && sda_now) begin
            nstops++; bitn = 0;
        end else if (!prev_scl && scl) begin
            if (bitn < 8) begin
                shreg = {shreg[6:0], sda_now};
                bitn++;
                if (bitn == 8) got_q.push_back(shreg);
            end else begin
                bitn = 0; byte_no++;
            end
        end else if (prev_scl && !scl) begin
            if (bitn == 8) begin
                if (byte_no == 0 && int'(idx) == nack_idx_cfg && nack_left > 0) begin
                    codec_pull = 1'b0; nack_left--;
                end else begin
                    codec_pull = 1'b1;
                end
            end else begin
                codec_pull = 1'b0;
            end
        end
        prev_scl = scl;
        prev_sda = sda_now;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i < got_q.size()) return got_q[i];
        return 8'hxx;
    endfunction

    // Word-level reference: frames, STOP count, final index and cycle cost of a pass.
    task automatic model(input int nidx, input int nn, output int cyc, output bit ok,
                         output int fidx, output int nstop);
        int left;
        left = nn; cyc = 0; ok = 1'b1; fidx = LUT_N - 1; nstop = 0;
        exp_q.delete();
        for (int i = 0; i < LUT_N; i++) begin
            int tries;
            bit sent;
            tries = 0; sent = 1'b0;
            while (!sent) begin
                exp_q.push_back({DEV, 1'b0});
                nstop++;
                if (i == nidx && left > 0) begin
                    left--; tries++;
                    cyc += 2 + 44 * QC;
                    if (!RETRY || tries > MAXR) begin
                        ok = 1'b0; fidx = i;
                        return;
                    end
                end else begin
                    exp_q.push_back(lut[i][15:8]);
                    exp_q.push_back(lut[i][7:0]);
                    cyc += 2 + 116 * QC;
                    sent = 1'b1;
                end
            end
        end
    endtask

    task automatic clear_mon(input int nidx, input int nn);
        nack_idx_cfg = nidx; nack_n_cfg = nn; mon_clr = 1'b1;
        @(negedge clk); @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic run_pass(input int nidx, input int nn, input bit pulse2, input string tag);
        int exp_cyc, exp_idx, exp_stops, n;
        bit exp_ok;
        clear_mon(nidx, nn);
        model(nidx, nn, exp_cyc, exp_ok, exp_idx, exp_stops);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".busy_rise"}, busy, 1);
        n = 0;
        while (!(done || err) && n < LIMIT) begin
            @(negedge clk);
            n++;
            start = pulse2 && (idx == 8'd2) && (n % 37 == 0);
        end
        start = 1'b0;
        chk({tag, ".timeout"}, (n < LIMIT), 1);
        chk({tag, ".cycles"}, n, exp_cyc);
        chk({tag, ".done"}, done, exp_ok);
        chk({tag, ".err"}, err, !exp_ok);
        chk({tag, ".busy_fall"}, busy, 0);
        chk({tag, ".index"}, idx, exp_idx);
        chk({tag, ".scl_idle"}, scl, 1);
        chk({tag, ".oe_idle"}, oe, 0);
        chk({tag, ".starts"}, nstarts, exp_stops);
        chk({tag, ".stops"}, nstops, exp_stops);
        chk({tag, ".nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("%s.byte%0d", tag, i), got_at(i), exp_q[i]);
    endtask

    task automatic rand_lut();
        for (int i = 0; i < LUT_N; i++) lut[i] = 16'($urandom);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0;
        lut[0] = 16'h0017; lut[1] = 16'h0217; lut[2] = 16'h0479; lut[3] = 16'h0679;
        lut[4] = 16'h0812; lut[5] = 16'h0A06; lut[6] = 16'h0C00; lut[7] = 16'h0E01;
        lut[8] = 16'h1002; lut[9] = 16'h1201;
        for (int i = LUT_N; i < 16; i++) lut[i] = 16'h0000;
        repeat (4) @(negedge clk);
        chk("reset.index", idx, 0);
        chk("reset.scl", scl, 1);
        chk("reset.oe", oe, 0);
        chk("reset.busy", busy, 0);
        chk("reset.done", done, 0);
        chk("reset.err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        run_pass(99, 0, 1'b0, "table");
        chk("table.b0", got_at(0), 8'h34);
        chk("table.b1", got_at(1), 8'h00);
        chk("table.b2", got_at(2), 8'h17);
        chk("table.b28", got_at(28), 8'h12);
        chk("table.b29", got_at(29), 8'h01);

        rand_lut();
        run_pass(4, 1, 1'b0, "nack1");
        rand_lut();
        run_pass(4, 2, 1'b0, "nack2");
        rand_lut();
        run_pass(4, 4, 1'b0, "nack4");
        rand_lut();
        run_pass(int'($urandom_range(0, LUT_N - 1)), int'($urandom_range(1, 5)), 1'b0, "nackrand");
        rand_lut();
        run_pass(99, 0, 1'b1, "busy_start");

        rand_lut();
        clear_mon(99, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (idx !== 8'd6 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.reach6", idx, 6);
        repeat (2 + 4 * QC + 10 * QC) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst.scl", scl, 1);
        chk("midrst.oe", oe, 0);
        chk("midrst.busy", busy, 0);
        chk("midrst.index", idx, 0);
        chk("midrst.done", done, 0);
        chk("midrst.err", err, 0);
        run_pass(99, 0, 1'b0, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
